// File: rtl/rom_reader_pkg.sv
// rom_reader_pkg: shared FSM states, mode constants and default settle time for the ROM scan reader
package rom_reader_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SETTLE,
    ST_CAPTURE,
    ST_EMIT,
    ST_NEXT,
    ST_DONE
  } state_t;
  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_AUTO = 1'b1;
  localparam int DEFAULT_SETTLE_CYCLES = 4;
endpackage

// File: rtl/rom_settle_timer.sv
// rom_settle_timer: loadable down-counter timing the PROM access window, expired when it reaches zero
module rom_settle_timer
  import rom_reader_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else if (load) cnt <= CW'(SETTLE_CYCLES - 1);
    else if (enable && cnt != '0) cnt <= cnt - CW'(1);
  end
  assign expired = cnt == '0;
endmodule

// File: rtl/rom_scan_reader.sv
// rom_scan_reader: parametrised PROM reader with manual inc/dec stepping and auto-scan streaming over valid/ready
module rom_scan_reader
  import rom_reader_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 9,
  parameter int DATA_WIDTH = 8,
  parameter int CS_WIDTH = 4,
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mode,
  input  logic                     start,
  input  logic                     inc_pulse,
  input  logic                     dec_pulse,
  input  logic [DATA_WIDTH-1:0]    chip_data_in,
  output logic [ADDRESS_WIDTH-1:0] chip_address,
  output logic [CS_WIDTH-1:0]      chip_select_n,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     data_valid,
  input  logic                     data_ready,
  output logic                     busy,
  output logic                     done
);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_MAX = {ADDRESS_WIDTH{1'b1}};
  state_t state, next_state;
  logic auto_q, expired, manual_step, auto_start, at_max;
  assign manual_step = mode == MODE_MANUAL && (inc_pulse ^ dec_pulse);
  assign auto_start = mode == MODE_AUTO && start;
  assign at_max = chip_address == ADDR_MAX;
  rom_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
    .clk(clk),
    .reset(reset),
    .load(state == ST_SETUP || (state == ST_IDLE && manual_step)),
    .enable(state == ST_SETTLE),
    .expired(expired)
  );
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else state <= next_state;
  end
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    next_state = manual_step ? ST_SETTLE : auto_start ? ST_SETUP : ST_IDLE;
      ST_SETUP:   next_state = ST_SETTLE;
      ST_SETTLE:  next_state = expired ? ST_CAPTURE : ST_SETTLE;
      ST_CAPTURE: next_state = auto_q ? ST_EMIT : ST_IDLE;
      ST_EMIT:    next_state = data_ready ? ST_NEXT : ST_EMIT;
      ST_NEXT:    next_state = at_max ? ST_DONE : ST_SETUP;
      ST_DONE:    next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end
  always_comb begin
    chip_select_n = state == ST_IDLE ? (mode == MODE_MANUAL ? '0 : '1) : state == ST_DONE ? '1 : '0;
    busy = auto_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      chip_address <= '0;
      data_out <= '0;
      data_valid <= 1'b0;
      auto_q <= 1'b0;
      done <= 1'b0;
    end else begin
      if (state == ST_IDLE && manual_step)
        chip_address <= inc_pulse ? chip_address + ADDRESS_WIDTH'(1) : chip_address - ADDRESS_WIDTH'(1);
      else if (state == ST_IDLE && auto_start) chip_address <= '0;
      else if (state == ST_NEXT && !at_max) chip_address <= chip_address + ADDRESS_WIDTH'(1);
      if (state == ST_CAPTURE) data_out <= chip_data_in;
      data_valid <= state == ST_CAPTURE || (state == ST_EMIT && !data_ready);
      if (state == ST_IDLE && auto_start) begin
        auto_q <= 1'b1;
        done <= 1'b0;
      end else if (state == ST_NEXT && at_max) begin
        auto_q <= 1'b0;
        done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rom_scan_reader.sv
// tb_rom_scan_reader: directed self-checking bench for rom_scan_reader with a slow PROM model
module tb_rom_scan_reader;
  localparam int AW = 4, DW = 8, CSW = 2, SC = 3;
  logic clk = 1'b0, reset = 1'b1, mode = 1'b0, start = 1'b0;
  logic inc_pulse = 1'b0, dec_pulse = 1'b0, data_ready = 1'b0;
  logic [DW-1:0] chip_data_in, data_out;
  logic [AW-1:0] chip_address;
  logic [CSW-1:0] chip_select_n;
  logic data_valid, busy, done;
  int n_checks = 0, n_fail = 0;
  logic [AW-1:0] prev_addr = '0;
  int age = 0;
  rom_scan_reader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .CS_WIDTH(CSW), .SETTLE_CYCLES(SC)) dut (
    .clk(clk), .reset(reset), .mode(mode), .start(start), .inc_pulse(inc_pulse), .dec_pulse(dec_pulse),
    .chip_data_in(chip_data_in), .chip_address(chip_address), .chip_select_n(chip_select_n),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (chip_address !== prev_addr) begin
      prev_addr <= chip_address;
      age <= 0;
    end else if (age < 10) age <= age + 1;
  end
  assign chip_data_in = (chip_address == prev_addr && age >= 2) ? (DW'(chip_address) ^ 8'hA5) : 8'hEE;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_manual(input logic i, input logic d);
    inc_pulse = i;
    dec_pulse = d;
    tick();
    inc_pulse = 1'b0;
    dec_pulse = 1'b0;
    repeat (4) tick();
  endtask
  task automatic test_reset();
    reset = 1'b1;
    mode = 1'b1;
    repeat (3) tick();
    n_checks++; if (chip_address !== 4'd0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", chip_address); end
    n_checks++; if (chip_select_n !== 2'b11) begin n_fail++; $display("FAIL reset_cs: got %b expected 11", chip_select_n); end
    n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", data_out); end
    n_checks++; if ({data_valid, busy, done} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {data_valid, busy, done}); end
    reset = 1'b0;
    mode = 1'b0;
    tick();
  endtask
  task automatic test_manual_inc();
    inc_pulse = 1'b1;
    tick();
    inc_pulse = 1'b0;
    n_checks++; if (chip_address !== 4'd1) begin n_fail++; $display("FAIL inc_addr: got %0d expected 1", chip_address); end
    n_checks++; if (chip_select_n !== 2'b00) begin n_fail++; $display("FAIL inc_cs: got %b expected 00", chip_select_n); end
    repeat (3) tick();
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL inc_early_valid: got %b expected 0", data_valid); end
    tick();
    n_checks++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL inc_valid: got %b expected 1", data_valid); end
    n_checks++; if (data_out !== 8'hA4) begin n_fail++; $display("FAIL inc_data: got %h expected a4", data_out); end
    tick();
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL inc_pulse_len: got %b expected 0", data_valid); end
  endtask
  task automatic test_wrap();
    int seen;
    do_manual(1'b0, 1'b1);
    n_checks++; if (chip_address !== 4'd0 || data_out !== 8'hA5) begin n_fail++; $display("FAIL dec_to_0: got %0d/%h expected 0/a5", chip_address, data_out); end
    do_manual(1'b0, 1'b1);
    n_checks++; if (chip_address !== 4'd15 || data_out !== 8'hAA || data_valid !== 1'b1) begin n_fail++; $display("FAIL dec_wrap: got %0d/%h/%b expected 15/aa/1", chip_address, data_out, data_valid); end
    do_manual(1'b1, 1'b0);
    n_checks++; if (chip_address !== 4'd0 || data_out !== 8'hA5 || data_valid !== 1'b1) begin n_fail++; $display("FAIL inc_wrap: got %0d/%h/%b expected 0/a5/1", chip_address, data_out, data_valid); end
    tick();
    inc_pulse = 1'b1;
    dec_pulse = 1'b1;
    tick();
    inc_pulse = 1'b0;
    dec_pulse = 1'b0;
    seen = 0;
    repeat (8) begin
      if (data_valid !== 1'b0 || chip_address !== 4'd0) seen++;
      tick();
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL inc_dec_both: got %0d changed cycles expected 0", seen); end
  endtask
  task automatic test_auto_sweep();
    int words, last_c, gap_bad, data_bad;
    words = 0; last_c = -1; gap_bad = 0; data_bad = 0;
    mode = 1'b1;
    data_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if (busy !== 1'b1 || done !== 1'b0 || chip_address !== 4'd0) begin n_fail++; $display("FAIL sweep_start: got busy=%b done=%b addr=%0d expected 1/0/0", busy, done, chip_address); end
    for (int c = 0; c < 300 && done !== 1'b1; c++) begin
      if (data_valid && data_ready) begin
        if (data_out !== (8'(words) ^ 8'hA5) || chip_address !== 4'(words)) data_bad++;
        if (last_c >= 0 && c - last_c != 7) gap_bad++;
        last_c = c;
        words++;
      end
      tick();
    end
    n_checks++; if (words != 16) begin n_fail++; $display("FAIL sweep_count: got %0d expected 16", words); end
    n_checks++; if (data_bad != 0) begin n_fail++; $display("FAIL sweep_data: got %0d bad words expected 0", data_bad); end
    n_checks++; if (gap_bad != 0) begin n_fail++; $display("FAIL sweep_gap: got %0d bad gaps expected 0", gap_bad); end
    n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL sweep_done: got done=%b busy=%b expected 1/0", done, busy); end
    n_checks++; if (chip_address !== 4'd15 || chip_select_n !== 2'b11) begin n_fail++; $display("FAIL sweep_end: got addr=%0d cs=%b expected 15/11", chip_address, chip_select_n); end
    repeat (3) tick();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL done_sticky: got %b expected 1", done); end
  endtask
  task automatic test_back_pressure();
    int found, bad;
    found = 0; bad = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL start_clears_done: got %b expected 0", done); end
    for (int c = 0; c < 200 && found == 0; c++) begin
      if (data_valid && chip_address == 4'd5) found = 1;
      else tick();
    end
    data_ready = 1'b0;
    n_checks++; if (found != 1) begin n_fail++; $display("FAIL bp_reach5: got %0d expected 1", found); end
    repeat (10) begin
      tick();
      if (data_valid !== 1'b1 || data_out !== 8'hA0 || chip_address !== 4'd5) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad); end
    data_ready = 1'b1;
    tick();
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got %b expected 0", data_valid); end
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      if (data_valid) found = 1;
      else tick();
    end
    n_checks++; if (found != 1 || chip_address !== 4'd6 || data_out !== 8'hA3) begin n_fail++; $display("FAIL bp_next: got found=%0d addr=%0d data=%h expected 1/6/a3", found, chip_address, data_out); end
  endtask
  task automatic test_reset_mid_scan();
    int found;
    found = 0;
    for (int c = 0; c < 200 && found == 0; c++) begin
      if (chip_address == 4'd9) found = 1;
      else tick();
    end
    n_checks++; if (found != 1) begin n_fail++; $display("FAIL rst_reach9: got %0d expected 1", found); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++; if (chip_address !== 4'd0 || chip_select_n !== 2'b11 || data_out !== 8'h00) begin n_fail++; $display("FAIL rst_mid_bus: got addr=%0d cs=%b data=%h expected 0/11/00", chip_address, chip_select_n, data_out); end
    n_checks++; if ({data_valid, busy, done} !== 3'b000) begin n_fail++; $display("FAIL rst_mid_flags: got %b expected 000", {data_valid, busy, done}); end
    start = 1'b1;
    tick();
    start = 1'b0;
    inc_pulse = 1'b1;
    start = 1'b1;
    tick();
    inc_pulse = 1'b0;
    start = 1'b0;
    n_checks++; if (chip_address !== 4'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL busy_ignore: got addr=%0d busy=%b expected 0/1", chip_address, busy); end
    found = 0;
    for (int c = 0; c < 30 && found == 0; c++) begin
      if (data_valid) found = 1;
      else tick();
    end
    n_checks++; if (found != 1 || chip_address !== 4'd0 || data_out !== 8'hA5) begin n_fail++; $display("FAIL rescan_first: got found=%0d addr=%0d data=%h expected 1/0/a5", found, chip_address, data_out); end
    for (int c = 0; c < 300 && done !== 1'b1; c++) tick();
    n_checks++; if (done !== 1'b1 || chip_address !== 4'd15) begin n_fail++; $display("FAIL rescan_done: got done=%b addr=%0d expected 1/15", done, chip_address); end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_manual_inc();
    test_wrap();
    test_auto_sweep();
    test_back_pressure();
    test_reset_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rom_scan_reader.md
Name: rom_scan_reader

Overview:
- Parametrised successor to the per-chip ROM readers.
- One instance serves any PROM of width DATA_WIDTH and depth 2^ADDRESS_WIDTH.
- Two modes:
  - Manual: step the address with inc/dec pulses.
  - Auto-scan: sweep the whole address space and stream every word out over a valid/ready handshake (toward a UART/host sink).
- Sits between the board button/switch logic and the chip GPIO; drives address, chip-select and captured data.

Parameters:
- ADDRESS_WIDTH, 9: chip address bus width; scan covers 0 .. 2^ADDRESS_WIDTH-1.
- DATA_WIDTH, 8: chip data bus width.
- CS_WIDTH, 4: number of active-low chip-select lines, all asserted together.
- SETTLE_CYCLES, 4: clk cycles between address drive and data capture (chip access time); legal range 1..255.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- mode  input  1  0 = manual, 1 = auto-scan; sampled only in IDLE.
- start  input  1  single-cycle pulse; begins an auto-scan when IDLE and mode=1.
- inc_pulse  input  1  single-cycle pulse, manual address +1.
- dec_pulse  input  1  single-cycle pulse, manual address -1.
- chip_data_in  input  DATA_WIDTH  data from PROM.
- chip_address  output  ADDRESS_WIDTH  address driven to PROM.
- chip_select_n  output  CS_WIDTH  active-low chip selects.
- data_out  output  DATA_WIDTH  last captured word.
- data_valid  output  1  data_out valid.
- data_ready  input  1  sink accepts data_out.
- busy  output  1  auto-scan in progress.
- done  output  1  scan finished; sticky until next start or reset.

Behaviour:
- Reset: clk and reset are the only clock/reset; reset is synchronous and active-high, wins over every other input on any cycle, mid-scan included.
- Reset values:
  - chip_address=0, chip_select_n=all 1, data_out=0.
  - data_valid=0, busy=0, done=0.
  - state=IDLE, settle counter=0.
- FSM states: IDLE, SETUP, SETTLE, CAPTURE, EMIT, NEXT, DONE.
- IDLE:
  - chip_select_n = all 0 when mode=0, otherwise all 1.
  - mode=0 and exactly one of inc/dec:
    - chip_address ±1 at the next edge, with modulo 2^ADDRESS_WIDTH wrap (max+1 -> 0, 0-1 -> max).
    - Then go to SETTLE.
  - inc and dec together: no change, stay IDLE.
  - mode=1 and start: chip_address=0, done=0, busy=1, go to SETUP.
- SETUP (auto only):
  - chip_select_n=all 0, address stable; 1 cycle, then SETTLE.
- SETTLE:
  - Counter loads SETTLE_CYCLES-1 on entry.
  - Decrements each cycle; at 0 go to CAPTURE. Total duration is SETTLE_CYCLES cycles.
  - inc/dec pulses during SETTLE are ignored (not queued).
- CAPTURE:
  - data_out <= chip_data_in, data_valid <= 1.
  - Manual: back to IDLE; data_valid is a 1-cycle pulse, data_ready ignored.
  - Auto: go to EMIT.
- EMIT:
  - Hold data_valid=1 and data_out stable until data_valid & data_ready at a clock edge.
  - Then data_valid=0, go to NEXT. Back-pressure is unbounded.
- NEXT:
  - If chip_address == 2^ADDRESS_WIDTH-1: go to DONE.
  - Else chip_address+1, go to SETUP.
- DONE:
  - busy=0, done=1, chip_select_n=all 1, chip_address held at max.
  - Go to IDLE the next cycle; done stays 1 until the next start or reset.
- Manual latency: pulse sampled at edge k -> address updates at k+1 -> data_valid high during the cycle after edge k+SETTLE_CYCLES+2.
- Auto throughput with data_ready tied 1: SETTLE_CYCLES+4 cycles per word (SETUP, SETTLE×N, CAPTURE, EMIT, NEXT).
- Auto word count: exactly 2^ADDRESS_WIDTH words, in ascending address order, none dropped or duplicated.
- While busy: mode, start, inc and dec are ignored.
- Counter width is ceil(log2(SETTLE_CYCLES+1)); address arithmetic stays at ADDRESS_WIDTH bits (no overflow bit kept).

Decomposition:
- Shared package rom_reader_pkg holds:
  - State encoding constants.
  - The mode constants MODE_MANUAL=0 and MODE_AUTO=1.
  - Default SETTLE_CYCLES.
- One natural sub-module, rom_settle_timer:
  - Loadable down-counter, parametrised by SETTLE_CYCLES.
  - Inputs: load, enable. Output: expired.
  - Instantiated once.

Test Plan:
- Common setup: AW=4, DW=8, CS=2, SETTLE=3; ROM model returns addr^8'hA5, valid only 2 cycles after an address change.
- Manual inc: mode=0, inc pulse at edge 0 -> chip_address=1 at edge 1; data_valid pulse at edge 5 with data_out=8'hA4; chip_select_n=2'b00.
- Wrap: mode=0, dec from address 0 -> chip_address=15, data_out=8'hAA; then inc -> chip_address=0, data_out=8'hA5; simultaneous inc+dec -> no address change and no data_valid.
- Auto sweep, ready=1: start -> exactly 16 handshakes, data 8'hA5..8'hAA in address order, 7 cycles apart; after the last word, done=1 and busy=0.
- Back-pressure: data_ready held 0 for 10 cycles at address 5 -> data_valid stays 1, data_out=8'hA0 stable, chip_address stays 5; after ready rises, address 6 follows.
- Reset mid-scan at address 9 -> next cycle all outputs at reset values; a following start rescans from 0; inc/start during busy have no effect.
